// File: rtl/monitor_overlay_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : monitor_overlay_ctrl_pkg
// Description : Shared state encoding and 6502 bus constants for the
//               debug-monitor overlay controller.
// Revision    : 1.0 - initial release
// ============================================================================
package monitor_overlay_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_NORMAL  = 2'd0,
        ST_ARMED   = 2'd1,
        ST_OVERLAY = 2'd2,
        ST_EXIT    = 2'd3
    } ovl_state_t;

    localparam logic [15:0] c_NMI_VEC_LO = 16'hFFFA;
    localparam logic [15:0] c_NMI_VEC_HI = 16'hFFFB;
    localparam logic [7:0]  c_OP_RTI     = 8'h40;

endpackage : monitor_overlay_ctrl_pkg
`default_nettype wire

// File: rtl/monitor_overlay_ctrl_nmi_pulse_gen.sv
`default_nettype none
// ============================================================================
// Module      : monitor_overlay_ctrl_nmi_pulse_gen
// Description : Loadable down-counter driving an active-low NMI for exactly
//               the loaded number of clk cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module monitor_overlay_ctrl_nmi_pulse_gen (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_load,
    input  logic [7:0] i_width,
    output logic       o_nmi_n,
    output logic       o_active
);

    logic [7:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= 8'd0;
        end else if (i_load) begin
            r_cnt <= i_width;
        end else if (r_cnt != 8'd0) begin
            r_cnt <= r_cnt - 8'd1;
        end
    end

    assign o_active = (r_cnt != 8'd0);
    assign o_nmi_n  = ~o_active;

endmodule : monitor_overlay_ctrl_nmi_pulse_gen
`default_nettype wire

// File: rtl/monitor_overlay_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : monitor_overlay_ctrl
// Description : Hands the 6502 bus between main memory and the $FFxx debug
//               monitor around a debugger-requested NMI.
// Revision    : 1.0 - initial release
// ============================================================================
module monitor_overlay_ctrl
    import monitor_overlay_ctrl_pkg::*;
#(
    parameter int         NMI_WIDTH   = 128,
    parameter int         ARM_TIMEOUT = 16,
    parameter logic [7:0] OVL_BASE    = 8'hFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        nmi_req,
    input  logic [15:0] cpu_addr,
    input  logic        cpu_rw,
    input  logic [7:0]  cpu_data,
    input  logic        sync,
    input  logic        bus_strobe,
    output logic        nmi_n,
    output logic        overlay_sel,
    output logic [7:0]  mon_addr,
    output logic        in_monitor,
    output logic        busy,
    output logic        arm_timeout_err
);

    ovl_state_t r_state;
    ovl_state_t w_state_next;
    logic [7:0] r_arm_cnt;
    logic [7:0] w_arm_inc;
    logic       r_err;
    logic       w_pulse_active;
    logic       w_accept;
    logic       w_win;
    logic       w_vec;
    logic       w_arm_clr;
    logic       w_arm_step;
    logic       w_err_set;

    assign w_win     = (cpu_addr[15:8] == OVL_BASE);
    assign w_vec     = (cpu_addr == c_NMI_VEC_LO) || (cpu_addr == c_NMI_VEC_HI);
    assign w_accept  = nmi_req && (r_state == ST_NORMAL) && !w_pulse_active;
    assign w_arm_inc = r_arm_cnt + 8'd1;

    monitor_overlay_ctrl_nmi_pulse_gen u_nmi_pulse_gen (
        .clk      (clk),
        .rst      (rst),
        .i_load   (w_accept),
        .i_width  (8'(NMI_WIDTH)),
        .o_nmi_n  (nmi_n),
        .o_active (w_pulse_active)
    );

    always_comb begin
        w_state_next = r_state;
        w_arm_clr    = 1'b0;
        w_arm_step   = 1'b0;
        w_err_set    = 1'b0;
        case (r_state)
            ST_NORMAL: begin
                if (w_accept) begin
                    w_state_next = ST_ARMED;
                    w_arm_clr    = 1'b1;
                end
            end
            ST_ARMED: begin
                // The vector fetch takes priority over a timeout on the same strobe.
                if (bus_strobe) begin
                    if (cpu_rw && (cpu_addr == c_NMI_VEC_LO)) begin
                        w_state_next = ST_OVERLAY;
                    end else if (w_arm_inc == 8'(ARM_TIMEOUT)) begin
                        w_state_next = ST_NORMAL;
                        w_err_set    = 1'b1;
                    end else begin
                        w_arm_step   = 1'b1;
                    end
                end
            end
            ST_OVERLAY: begin
                if (bus_strobe && sync && w_win && (cpu_data == c_OP_RTI)) begin
                    w_state_next = ST_EXIT;
                end
            end
            ST_EXIT: begin
                // First user opcode fetch after the RTI stack pulls.
                if (bus_strobe && sync) begin
                    w_state_next = ST_NORMAL;
                end
            end
            default: w_state_next = ST_NORMAL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_NORMAL;
            r_arm_cnt <= 8'd0;
            r_err     <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_arm_clr) begin
                r_arm_cnt <= 8'd0;
            end else if (w_arm_step) begin
                r_arm_cnt <= w_arm_inc;
            end
            if (w_accept) begin
                r_err <= 1'b0;
            end else if (w_err_set) begin
                r_err <= 1'b1;
            end
        end
    end

    assign overlay_sel     = ((r_state == ST_ARMED) && w_vec) ||
                             (((r_state == ST_OVERLAY) || (r_state == ST_EXIT)) && w_win);
    assign mon_addr        = cpu_addr[7:0];
    assign in_monitor      = (r_state == ST_OVERLAY) || (r_state == ST_EXIT);
    assign busy            = (r_state != ST_NORMAL) || w_pulse_active;
    assign arm_timeout_err = r_err;

endmodule : monitor_overlay_ctrl
`default_nettype wire

// File: tb/tb_monitor_overlay_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_monitor_overlay_ctrl
// Description : Scenario tasks plus randomized traffic against a behavioural
//               model of the monitor overlay sequencing.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_monitor_overlay_ctrl;

    localparam int         NMI_W  = 128;
    localparam int         ARM_TO = 16;
    localparam logic [7:0] BASE   = 8'hFF;

    logic        clk = 1'b0;
    logic        rst;
    logic        nmi_req;
    logic [15:0] cpu_addr;
    logic        cpu_rw;
    logic [7:0]  cpu_data;
    logic        sync;
    logic        bus_strobe;
    logic        nmi_n;
    logic        overlay_sel;
    logic [7:0]  mon_addr;
    logic        in_monitor;
    logic        busy;
    logic        arm_timeout_err;

    int errors = 0;
    int checks = 0;

    // Model: where the CPU is in the debug-entry story, plus NMI cycles left.
    // 0 = user code, 1 = waiting for vector, 2 = running monitor, 3 = leaving.
    int m_phase = 0;
    int m_low   = 0;
    int m_arm   = 0;
    bit m_err   = 0;

    monitor_overlay_ctrl #(
        .NMI_WIDTH   (NMI_W),
        .ARM_TIMEOUT (ARM_TO),
        .OVL_BASE    (BASE)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .nmi_req         (nmi_req),
        .cpu_addr        (cpu_addr),
        .cpu_rw          (cpu_rw),
        .cpu_data        (cpu_data),
        .sync            (sync),
        .bus_strobe      (bus_strobe),
        .nmi_n           (nmi_n),
        .overlay_sel     (overlay_sel),
        .mon_addr        (mon_addr),
        .in_monitor      (in_monitor),
        .busy            (busy),
        .arm_timeout_err (arm_timeout_err)
    );

    always #5 clk = ~clk;

    function automatic logic exp_ovl();
        logic in_win;
        in_win = (cpu_addr[15:8] == BASE);
        if (m_phase == 1) return (cpu_addr == 16'hFFFA) || (cpu_addr == 16'hFFFB);
        if (m_phase >= 2) return in_win;
        return 1'b0;
    endfunction

    task automatic model_step();
        bit take;
        take = nmi_req && (m_phase == 0) && (m_low == 0);
        if (rst) begin
            m_phase = 0; m_low = 0; m_arm = 0; m_err = 0;
        end else begin
            if (m_low > 0) m_low--;
            if (m_phase == 0) begin
                if (take) begin
                    m_phase = 1; m_low = NMI_W; m_arm = 0; m_err = 0;
                end
            end else if (m_phase == 1) begin
                if (bus_strobe) begin
                    if (cpu_rw && cpu_addr == 16'hFFFA) m_phase = 2;
                    else begin
                        m_arm++;
                        if (m_arm >= ARM_TO) begin m_phase = 0; m_err = 1; end
                    end
                end
            end else if (m_phase == 2) begin
                if (bus_strobe && sync && cpu_addr[15:8] == BASE && cpu_data == 8'h40)
                    m_phase = 3;
            end else begin
                if (bus_strobe && sync) m_phase = 0;
            end
        end
    endtask

    // Drive a bus cycle just after the edge and wait to the mid-cycle sample point.
    task automatic set_bus(input logic [15:0] a, input logic rw_i, input logic [7:0] d,
                           input logic s, input logic stb, input logic req);
        cpu_addr = a; cpu_rw = rw_i; cpu_data = d; sync = s;
        bus_strobe = stb; nmi_req = req;
        #4;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        bus_strobe = 1'b0; nmi_req = 1'b0; sync = 1'b0; rst = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        set_bus(16'h0000, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
        tick();
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            set_bus(16'h1234, 1'b1, 8'hEA, 1'b0, 1'b0, 1'b0);
            tick();
        end
    endtask

    task automatic wait_pulse_end();
        int guard;
        guard = 0;
        set_bus(16'h1234, 1'b1, 8'hEA, 1'b0, 1'b0, 1'b0);
        while (nmi_n !== 1'b1 && guard < 400) begin
            tick();
            set_bus(16'h1234, 1'b1, 8'hEA, 1'b0, 1'b0, 1'b0);
            guard++;
        end
        checks++;
        if (guard >= 400) begin
            errors++;
            $display("FAIL pulse_end_timeout: nmi_n=%b after %0d cycles, required 1", nmi_n, guard);
        end
    endtask

    task automatic enter_monitor();
        set_bus(16'h1234, 1'b1, 8'hEA, 1'b0, 1'b0, 1'b1);
        tick();
        wait_pulse_end();
        set_bus(16'hFFFA, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0);
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        set_bus(16'hFFFA, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
        checks++; if (nmi_n !== 1'b1) begin errors++; $display("FAIL reset_nmi_n: got %b want 1", nmi_n); end
        checks++; if (overlay_sel !== 1'b0) begin errors++; $display("FAIL reset_overlay: got %b want 0", overlay_sel); end
        checks++; if (in_monitor !== 1'b0) begin errors++; $display("FAIL reset_in_monitor: got %b want 0", in_monitor); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (arm_timeout_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", arm_timeout_err); end
        tick();
    endtask

    task automatic test_entry();
        int lows;
        int busy_bad;
        lows = 0; busy_bad = 0;
        do_reset();
        set_bus(16'h1234, 1'b1, 8'hEA, 1'b0, 1'b0, 1'b1);
        tick();
        for (int i = 0; i < 300; i++) begin
            set_bus(16'h1234, 1'b1, 8'hEA, 1'b0, 1'b0, 1'b0);
            if (nmi_n === 1'b0) lows++;
            if (busy !== 1'b1) busy_bad++;
            tick();
        end
        checks++; if (lows !== NMI_W) begin errors++; $display("FAIL entry_pulse_width: got %0d want %0d", lows, NMI_W); end
        checks++; if (busy_bad !== 0) begin errors++; $display("FAIL entry_busy: %0d cycles busy!=1, want 0", busy_bad); end
        set_bus(16'hFFFA, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0);
        checks++; if (overlay_sel !== 1'b1) begin errors++; $display("FAIL entry_vec_overlay: got %b want 1", overlay_sel); end
        checks++; if (in_monitor !== 1'b0) begin errors++; $display("FAIL entry_armed_in_monitor: got %b want 0", in_monitor); end
        tick();
        set_bus(16'hFFFB, 1'b1, 8'hF0, 1'b0, 1'b1, 1'b0);
        checks++; if (in_monitor !== 1'b1) begin errors++; $display("FAIL entry_in_monitor: got %b want 1", in_monitor); end
        checks++; if (overlay_sel !== 1'b1) begin errors++; $display("FAIL entry_vec_hi: got %b want 1", overlay_sel); end
        tick();
    endtask

    task automatic test_window();
        set_bus(16'hFF10, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0);
        checks++; if (overlay_sel !== 1'b1 || mon_addr !== 8'h10) begin
            errors++; $display("FAIL window_ff10: sel=%b addr=%h want 1/10", overlay_sel, mon_addr); end
        tick();
        set_bus(16'hFE10, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0);
        checks++; if (overlay_sel !== 1'b0) begin errors++; $display("FAIL window_fe10: sel=%b want 0", overlay_sel); end
        tick();
        set_bus(16'hFFF3, 1'b0, 8'h5A, 1'b0, 1'b1, 1'b0);
        checks++; if (overlay_sel !== 1'b1 || mon_addr !== 8'hF3) begin
            errors++; $display("FAIL window_write_fff3: sel=%b addr=%h want 1/f3", overlay_sel, mon_addr); end
        tick();
    endtask

    task automatic test_exit();
        int bad;
        bad = 0;
        set_bus(16'hFF40, 1'b1, 8'h40, 1'b1, 1'b1, 1'b0);
        tick();
        for (int i = 0; i < 5; i++) begin
            set_bus(16'h01FD + 16'(i % 3), 1'b1, 8'h00, 1'b0, 1'b1, 1'b0);
            if (in_monitor !== 1'b1 || overlay_sel !== 1'b0) bad++;
            tick();
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL exit_pulls: %0d bad cycles, want 0", bad); end
        set_bus(16'hFF20, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0);
        checks++; if (overlay_sel !== 1'b1) begin errors++; $display("FAIL exit_window_held: sel=%b want 1", overlay_sel); end
        tick();
        set_bus(16'h0200, 1'b1, 8'hA9, 1'b1, 1'b1, 1'b0);
        checks++; if (overlay_sel !== 1'b0) begin errors++; $display("FAIL exit_user_fetch: sel=%b want 0", overlay_sel); end
        tick();
        set_bus(16'hFF10, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
        checks++; if (in_monitor !== 1'b0 || overlay_sel !== 1'b0) begin
            errors++; $display("FAIL exit_normal: in_mon=%b sel=%b want 0/0", in_monitor, overlay_sel); end
        tick();
    endtask

    task automatic test_timeout();
        logic [15:0] a;
        do_reset();
        set_bus(16'h1234, 1'b1, 8'hEA, 1'b0, 1'b0, 1'b1);
        tick();
        for (int i = 0; i < ARM_TO; i++) begin
            a = 16'($urandom_range(0, 16'hFEFF));
            set_bus(a, 1'($urandom), 8'($urandom), 1'($urandom), 1'b1, 1'b0);
            tick();
        end
        set_bus(16'hFFFA, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
        checks++; if (arm_timeout_err !== 1'b1) begin errors++; $display("FAIL timeout_err: got %b want 1", arm_timeout_err); end
        checks++; if (overlay_sel !== 1'b0 || in_monitor !== 1'b0) begin
            errors++; $display("FAIL timeout_normal: sel=%b in_mon=%b want 0/0", overlay_sel, in_monitor); end
        tick();
        wait_pulse_end();
        set_bus(16'h1234, 1'b1, 8'hEA, 1'b0, 1'b0, 1'b1);
        tick();
        set_bus(16'h1234, 1'b1, 8'hEA, 1'b0, 1'b0, 1'b0);
        checks++; if (arm_timeout_err !== 1'b0 || nmi_n !== 1'b0) begin
            errors++; $display("FAIL timeout_clear: err=%b nmi_n=%b want 0/0", arm_timeout_err, nmi_n); end
        tick();
    endtask

    task automatic test_simultaneous();
        do_reset();
        set_bus(16'h1234, 1'b1, 8'hEA, 1'b0, 1'b0, 1'b1);
        tick();
        for (int i = 0; i < ARM_TO - 1; i++) begin
            set_bus(16'h0300 + 16'(i), 1'b1, 8'h00, 1'b0, 1'b1, 1'b0);
            tick();
        end
        set_bus(16'hFFFA, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0);
        tick();
        set_bus(16'h1234, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
        checks++; if (in_monitor !== 1'b1 || arm_timeout_err !== 1'b0) begin
            errors++; $display("FAIL vector_beats_timeout: in_mon=%b err=%b want 1/0", in_monitor, arm_timeout_err); end
        tick();
    endtask

    task automatic test_ignored();
        int lows;
        int bad;
        do_reset();
        enter_monitor();
        bad = 0;
        set_bus(16'hFF00, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1);
        tick();
        for (int i = 0; i < 10; i++) begin
            set_bus(16'hFF00, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
            if (nmi_n !== 1'b1 || in_monitor !== 1'b1) bad++;
            tick();
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL ignore_in_overlay: %0d bad cycles, want 0", bad); end
        do_reset();
        lows = 0;
        set_bus(16'h1234, 1'b1, 8'hEA, 1'b0, 1'b0, 1'b1);
        tick();
        for (int i = 0; i < 300; i++) begin
            set_bus(16'h1234, 1'b1, 8'hEA, 1'b0, 1'b0, (i == 20 || i == 90));
            if (nmi_n === 1'b0) lows++;
            tick();
        end
        checks++; if (lows !== NMI_W) begin errors++; $display("FAIL ignore_no_restart: low=%0d want %0d", lows, NMI_W); end
    endtask

    task automatic test_reset_mid_pulse();
        do_reset();
        set_bus(16'h1234, 1'b1, 8'hEA, 1'b0, 1'b0, 1'b1);
        tick();
        idle_cycles(39);
        rst = 1'b1;
        set_bus(16'hFFFA, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0);
        checks++; if (nmi_n !== 1'b0) begin errors++; $display("FAIL midpulse_active: nmi_n=%b want 0", nmi_n); end
        tick();
        set_bus(16'hFFFA, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
        checks++; if (nmi_n !== 1'b1 || overlay_sel !== 1'b0 || busy !== 1'b0 || in_monitor !== 1'b0) begin
            errors++; $display("FAIL midpulse_reset: nmi_n=%b sel=%b busy=%b in_mon=%b want 1/0/0/0",
                               nmi_n, overlay_sel, busy, in_monitor); end
        tick();
    endtask

    task automatic test_random();
        logic [15:0] a;
        int          bad;
        int          sel;
        bad = 0;
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            sel = int'($urandom_range(0, 7));
            case (sel)
                0, 1:    a = 16'hFFFA;
                2:       a = 16'hFFFB;
                3, 4:    a = {8'hFF, 8'($urandom)};
                default: a = 16'($urandom);
            endcase
            rst = ($urandom_range(0, 499) == 0);
            set_bus(a, ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0) ? 8'h40 : 8'($urandom),
                    1'($urandom), ($urandom_range(0, 1) == 0), ($urandom_range(0, 40) == 0));
            if (overlay_sel !== exp_ovl() || mon_addr !== a[7:0] || nmi_n !== (m_low == 0) ||
                in_monitor !== (m_phase >= 2) || busy !== (m_phase != 0 || m_low != 0) ||
                arm_timeout_err !== m_err) begin
                if (bad < 10)
                    $display("FAIL random_cycle%0d: sel=%b nmi_n=%b in_mon=%b busy=%b err=%b want %b/%b/%b/%b/%b",
                             i, overlay_sel, nmi_n, in_monitor, busy, arm_timeout_err, exp_ovl(),
                             (m_low == 0), (m_phase >= 2), (m_phase != 0 || m_low != 0), m_err);
                bad++;
            end
            tick();
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL random_traffic: %0d bad cycles, want 0", bad); end
    endtask

    initial begin
        rst = 1'b1; nmi_req = 1'b0; cpu_addr = 16'h0000; cpu_rw = 1'b1;
        cpu_data = 8'h00; sync = 1'b0; bus_strobe = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_entry();
        test_window();
        test_exit();
        test_timeout();
        test_simultaneous();
        test_ignored();
        test_reset_mid_pulse();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_monitor_overlay_ctrl
`default_nettype wire
